// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the IF stage: registered fetch with
// stall/flush, PC fault reporting, and a run-time program-load mode.
module instr_mem_sync #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter string       INIT_FILE = "test_program1.txt",
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_ld_mode,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [31:0]       i_ld_data,
  output logic [31:0]       o_instr,
  output logic              o_valid,
  output logic              o_fault,
  output logic              o_busy,
  output logic [15:0]       o_ld_cnt
);

  localparam int unsigned MEM_AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e            state_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              fault_q;
  logic              busy_q;
  logic [15:0]       ld_cnt_q;
  logic [15:0]       ld_cnt_d;

  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] f_idx;
  logic [ADDR_W-1:0] l_idx;
  logic              fetch_ok;
  logic              ld_ok;
  logic              ld_wr;

  // Word indices kept at full address width so the range check sees every upper bit.
  assign f_idx    = {2'b00, i_addr[ADDR_W-1:2]};
  assign l_idx    = {2'b00, i_ld_addr[ADDR_W-1:2]};
  assign fetch_ok = (i_addr[1:0] == 2'b00) && (f_idx < ADDR_W'(DEPTH));
  assign ld_ok    = (i_ld_addr[1:0] == 2'b00) && (l_idx < ADDR_W'(DEPTH));
  assign ld_wr    = (state_q == ST_LOAD) && i_ld_we && ld_ok;
  assign ld_cnt_d = (ld_cnt_q == '1) ? ld_cnt_q : ld_cnt_q + 16'd1;

  // Contents are deliberately outside reset; a write in the reset cycle is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && ld_wr) begin
      mem_q[l_idx[MEM_AW-1:0]] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RUN;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      ld_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (i_flush) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
          end else if (i_stall) begin
            instr_q <= instr_q;
            valid_q <= valid_q;
            fault_q <= fault_q;
          end else if (i_req) begin
            if (fetch_ok) begin
              instr_q <= mem_q[f_idx[MEM_AW-1:0]];
              fault_q <= 1'b0;
            end else begin
              instr_q <= NOP_INSTR;
              fault_q <= 1'b1;
            end
            valid_q <= 1'b1;
          end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
          end
          if (i_ld_mode) begin
            state_q  <= ST_LOAD;
            busy_q   <= 1'b1;
            ld_cnt_q <= '0;
          end
        end
        ST_LOAD: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
          if (ld_wr) begin
            ld_cnt_q <= ld_cnt_d;
          end
          if (!i_ld_mode) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_instr  = instr_q;
  assign o_valid  = valid_q;
  assign o_fault  = fault_q;
  assign o_busy   = busy_q;
  assign o_ld_cnt = ld_cnt_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: expected outputs queued at drive time,
// popped and checked one cycle later.
module tb_instr_mem_sync;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, req, stall, flush, ld_mode, ld_we;
  logic [31:0] addr, ld_addr, ld_data;
  logic [31:0] o_instr;
  logic        o_valid, o_fault, o_busy;
  logic [15:0] o_ld_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic        busy;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  instr_mem_sync #(
    .DEPTH(DEPTH),
    .ADDR_W(32),
    .INIT_FILE(""),
    .NOP_INSTR(NOP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr),
    .i_stall(stall), .i_flush(flush), .i_ld_mode(ld_mode),
    .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .o_instr(o_instr), .o_valid(o_valid), .o_fault(o_fault),
    .o_busy(o_busy), .o_ld_cnt(o_ld_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] instr, input logic valid,
                      input logic fault, input logic busy);
    exp_t e;
    e.tag = tag; e.instr = instr; e.valid = valid; e.fault = fault; e.busy = busy;
    sbq.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One clock, then compare the oldest queued expectation against the outputs.
  task automatic step();
    exp_t e;
    adv();
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".instr"}, o_instr, e.instr);
      chk({e.tag, ".valid"}, {31'd0, o_valid}, {31'd0, e.valid});
      chk({e.tag, ".fault"}, {31'd0, o_fault}, {31'd0, e.fault});
      chk({e.tag, ".busy"},  {31'd0, o_busy},  {31'd0, e.busy});
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] a);
    logic [31:0] idx;
    req = 1'b1; addr = a; stall = 1'b0; flush = 1'b0;
    idx = a >> 2;
    if (a[1:0] != 2'b00 || idx >= DEPTH) push(tag, NOP, 1'b1, 1'b1, 1'b0);
    else                                 push(tag, model[idx[7:0]], 1'b1, 1'b0, 1'b0);
    step();
    req = 1'b0;
  endtask

  task automatic ld_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] idx;
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    idx = a >> 2;
    if (a[1:0] == 2'b00 && idx < DEPTH) model[idx[7:0]] = d;
    push(tag, NOP, 1'b0, 1'b0, 1'b1);
    step();
    ld_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; stall = 1'b0; flush = 1'b0;
    ld_mode = 1'b0; ld_we = 1'b0; addr = '0; ld_addr = '0; ld_data = '0;

    push("reset", NOP, 1'b0, 1'b0, 1'b0);
    step();
    chk("reset.ld_cnt", {16'd0, o_ld_cnt}, 32'd0);
    rst = 1'b0;

    // Program the image through LOAD mode.
    ld_mode = 1'b1;
    push("enter_load", NOP, 1'b0, 1'b0, 1'b1);
    step();
    ld_write("ld_w0", 32'd0,  32'h0050_0093);
    ld_write("ld_w1", 32'd4,  32'h00A0_0113);
    ld_write("ld_w2", 32'd8,  32'h0020_81B3);
    ld_write("ld_w3", 32'd12, 32'h0000_0013);
    ld_write("ld_wlast", 32'd4 * (DEPTH - 1), 32'hCAFE_F00D);
    chk("ld_cnt_five", {16'd0, o_ld_cnt}, 32'd5);
    ld_mode = 1'b0;
    push("exit_load", NOP, 1'b0, 1'b0, 1'b0);
    step();

    fetch("f0", 32'd0);
    fetch("f4", 32'd4);
    fetch("f8", 32'd8);
    fetch("f12", 32'd12);

    // Stall holds the previous result, flush beats stall.
    fetch("st_req", 32'd4);
    for (int unsigned i = 0; i < 3; i++) begin
      req = 1'b1; addr = 32'd8; stall = 1'b1;
      push("stall_hold", 32'h00A0_0113, 1'b1, 1'b0, 1'b0);
      step();
    end
    req = 1'b1; stall = 1'b1; flush = 1'b1;
    push("flush_over_stall", NOP, 1'b0, 1'b0, 1'b0);
    step();
    stall = 1'b0; flush = 1'b0;
    fetch("resume", 32'd8);

    fetch("mis6", 32'd6);
    req = 1'b1; addr = 32'd0; stall = 1'b1;
    push("stall_fault", NOP, 1'b1, 1'b1, 1'b0);
    step();
    stall = 1'b0;
    fetch("oor", 32'd4 * DEPTH);
    fetch("oor_high", 32'hFFFF_FFFC);
    fetch("addr0", 32'd0);
    fetch("last", 32'd4 * (DEPTH - 1));
    req = 1'b0;
    push("idle", NOP, 1'b0, 1'b0, 1'b0);
    step();

    // RUN-mode write strobes must not touch memory.
    ld_we = 1'b1; ld_addr = 32'd0; ld_data = 32'hBAD0_BAD0;
    fetch("run_we_ignored", 32'd4);
    ld_we = 1'b0;

    // Rising i_ld_mode: fetch still served, same-cycle write ignored.
    ld_mode = 1'b1; req = 1'b1; addr = 32'd0;
    ld_we = 1'b1; ld_addr = 32'd4; ld_data = 32'hBADB_AD00;
    push("rise_fetch", 32'h0050_0093, 1'b1, 1'b0, 1'b1);
    step();
    req = 1'b1; flush = 1'b1;
    ld_write("ld_dead", 32'd8, 32'hDEAD_BEEF);
    ld_write("ld_mis", 32'd3, 32'h1234_5678);
    ld_write("ld_oor", 32'd4 * DEPTH, 32'h1234_5678);
    req = 1'b0; flush = 1'b0;
    chk("ld_cnt_one", {16'd0, o_ld_cnt}, 32'd1);
    ld_mode = 1'b0;
    push("exit_load2", NOP, 1'b0, 1'b0, 1'b0);
    step();
    fetch("after_load8", 32'd8);
    fetch("rise_we_dropped", 32'd4);
    fetch("run_we_dropped", 32'd0);
    chk("ld_cnt_held", {16'd0, o_ld_cnt}, 32'd1);

    // Reset in the middle of LOAD with a write pending.
    ld_mode = 1'b1;
    push("enter_load3", NOP, 1'b0, 1'b0, 1'b1);
    step();
    ld_write("ld_pre_rst", 32'd12, 32'h55AA_55AA);
    chk("ld_cnt_pre_rst", {16'd0, o_ld_cnt}, 32'd1);
    rst = 1'b1; ld_we = 1'b1; ld_addr = 32'd0; ld_data = 32'h0BAD_F00D;
    push("rst_mid_load", NOP, 1'b0, 1'b0, 1'b0);
    step();
    chk("rst_ld_cnt", {16'd0, o_ld_cnt}, 32'd0);
    rst = 1'b0; ld_we = 1'b0; ld_mode = 1'b0;
    fetch("persist12", 32'd12);
    fetch("rst_we_dropped", 32'd0);

    // Count saturation over a long LOAD session.
    ld_mode = 1'b1;
    push("enter_load4", NOP, 1'b0, 1'b0, 1'b1);
    step();
    ld_we = 1'b1; ld_addr = 32'd16; ld_data = 32'h0000_0001;
    repeat (65534) adv();
    chk("ld_cnt_fffe", {16'd0, o_ld_cnt}, 32'h0000_FFFE);
    adv();
    chk("ld_cnt_ffff", {16'd0, o_ld_cnt}, 32'h0000_FFFF);
    repeat (4465) adv();
    chk("ld_cnt_sat", {16'd0, o_ld_cnt}, 32'h0000_FFFF);
    ld_we = 1'b0; ld_mode = 1'b0;
    adv();
    chk("busy_clear", {31'd0, o_busy}, 32'd0);
    chk("sbq_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
